// File: rtl/qam_mapper_pipe_pkg.sv
// Shared types, constants and mapping helpers for the QAM mapper.
//   mode_t        modulation selector (BPSK / QPSK / 16-QAM / reserved)
//   bits_per_sym  number of serial bits consumed per symbol in a mode
//   map_sym       Gray-coded mapping of up to 4 bits (b0 first) to a Q15 I/Q pair {I, Q}
package qam_mapper_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'd0,
        MODE_QPSK  = 2'd1,
        MODE_16QAM = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_t;

    localparam logic signed [15:0] P1       = 16'sh7FFF;
    localparam logic signed [15:0] A_QPSK   = 16'sh5A82;
    localparam logic signed [15:0] L1_16QAM = 16'sh287A;
    localparam logic signed [15:0] L3_16QAM = 16'sh796E;

    // Reserved mode behaves as QPSK.
    function automatic logic [2:0] bits_per_sym(mode_t m);
        case (m)
            MODE_BPSK:  return 3'd1;
            MODE_16QAM: return 3'd4;
            default:    return 3'd2;
        endcase
    endfunction

    // Bit value 0 maps to the positive level, 1 to the negative level.
    function automatic logic signed [15:0] apply_sign(logic neg, logic signed [15:0] mag);
        return neg ? -mag : mag;
    endfunction

    function automatic logic [31:0] map_sym(mode_t m, logic [3:0] b);
        logic signed [15:0] i_val;
        logic signed [15:0] q_val;
        case (m)
            MODE_BPSK: begin
                i_val = apply_sign(b[0], P1);
                q_val = '0;
            end
            MODE_16QAM: begin
                i_val = apply_sign(b[0], b[1] ? L3_16QAM : L1_16QAM);
                q_val = apply_sign(b[2], b[3] ? L3_16QAM : L1_16QAM);
            end
            default: begin
                i_val = apply_sign(b[0], A_QPSK);
                q_val = apply_sign(b[1], A_QPSK);
            end
        endcase
        return {i_val, q_val};
    endfunction

endpackage

// File: rtl/qam_mapper_pipe_if.sv
// Bit-in / symbol-out bus of the QAM mapper.
//   mode, in_data, in_valid, in_last, in_ready   serial bit input handshake
//   out_i, out_q, out_last, out_valid, out_ready  symbol output handshake
// master: bit source / symbol sink side; slave: the mapper itself.
interface qam_mapper_pipe_if #(
    parameter int unsigned IQ_W = 16
);
    logic [1:0]      mode;
    logic            in_data;
    logic            in_valid;
    logic            in_last;
    logic            in_ready;
    logic [IQ_W-1:0] out_i;
    logic [IQ_W-1:0] out_q;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output mode, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_i, out_q, out_last, out_valid
    );

    modport slave (
        input  mode, in_data, in_valid, in_last, out_ready,
        output in_ready, out_i, out_q, out_last, out_valid
    );
endinterface

// File: rtl/qam_mapper_pipe_sym_fifo.sv
// Synchronous first-word-fall-through FIFO for mapped symbols.
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i/wdata_i write side (ignored while full)
//   pop_i/rdata_o  read side; rdata_o shows the head whenever not empty
//   full_o/empty_o occupancy flags
//   full_next_o    full flag as it will be after this edge (for registered ready)
module sym_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             full_next_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full_o   = (count_q == CntW'(DEPTH));
        empty_o  = (count_q == '0);
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
        full_next_o = (count_d == CntW'(DEPTH));
        rdata_o     = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end
endmodule

// File: rtl/qam_mapper_pipe.sv
// Serial-bit to I/Q symbol mapper (BPSK / QPSK / Gray 16-QAM) with output FIFO.
//   clock, reset  single clock, synchronous active-high reset
//   bus (slave)   bit input handshake with mode/last, symbol output handshake
// Bits accumulate b0-first; mode is latched on the first bit of each symbol. A symbol
// completes when the latched bit count is reached or on in_last (zero-padded, out_last=1).
module qam_mapper_pipe
    import qam_mapper_pipe_pkg::*;
#(
    parameter int unsigned IQ_W       = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    qam_mapper_pipe_if.slave  bus
);
    localparam int unsigned Width = 2 * IQ_W + 1;
    localparam int unsigned Shift = 16 - IQ_W;

    logic [3:0] bits_q, bits_d;
    logic [2:0] cnt_q, cnt_d;
    mode_t      mode_q, mode_d;
    logic       in_ready_q;

    logic               accept, complete, push, pop;
    mode_t              eff_mode;
    logic [3:0]         sym_bits;
    logic [31:0]        sym16;
    logic signed [15:0] i16, q16;
    logic [IQ_W-1:0]    i_sc, q_sc;
    logic [Width-1:0]   wdata, rdata;
    logic               fifo_full, fifo_empty, fifo_full_next;

    always_comb begin
        accept   = bus.in_valid && in_ready_q;
        // Mode only follows the input at a symbol boundary.
        eff_mode = (cnt_q == 3'd0) ? mode_t'(bus.mode) : mode_q;
        sym_bits = bits_q;
        sym_bits[cnt_q[1:0]] = bus.in_data;
        complete = accept && (((cnt_q + 3'd1) == bits_per_sym(eff_mode)) || bus.in_last);

        // Unfilled positions are already zero, which is the flush padding.
        sym16 = map_sym(eff_mode, sym_bits);
        i16   = sym16[31:16];
        q16   = sym16[15:0];
        i_sc  = IQ_W'(i16 >>> Shift);
        q_sc  = IQ_W'(q16 >>> Shift);
        wdata = {bus.in_last, i_sc, q_sc};

        bits_d = bits_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (accept) begin
            mode_d = eff_mode;
            if (complete) begin
                bits_d = '0;
                cnt_d  = '0;
            end else begin
                bits_d = sym_bits;
                cnt_d  = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bits_q     <= '0;
            cnt_q      <= '0;
            mode_q     <= MODE_BPSK;
            in_ready_q <= 1'b0;
        end else begin
            bits_q     <= bits_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            in_ready_q <= !fifo_full_next;
        end
    end

    always_comb begin
        push = complete && !fifo_full;
        pop  = !fifo_empty && bus.out_ready;
    end

    sym_fifo #(
        .WIDTH (Width),
        .DEPTH (FIFO_DEPTH)
    ) u_sym_fifo (
        .clk_i       (clock),
        .rst_i       (reset),
        .push_i      (push),
        .wdata_i     (wdata),
        .pop_i       (pop),
        .rdata_o     (rdata),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .full_next_o (fifo_full_next)
    );

    always_comb begin
        bus.in_ready  = in_ready_q;
        bus.out_valid = !fifo_empty;
        // Outputs read zero while nothing is queued.
        {bus.out_last, bus.out_i, bus.out_q} = fifo_empty ? '0 : rdata;
    end
endmodule

// File: tb/tb_qam_mapper_pipe.sv
// Directed bench: u0 (IQ_W=16, depth 2) carries the main scenarios; u1 (IQ_W=12, depth 3)
// sees the same inputs and is checked for output scaling after a common reset.
module tb_qam_mapper_pipe;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [1:0] drv_mode = 2'd1;
    logic drv_data = 1'b0, drv_valid = 1'b0, drv_last = 1'b0, drv_ready = 1'b1;
    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    qam_mapper_pipe_if #(.IQ_W(16)) b0 ();
    qam_mapper_pipe_if #(.IQ_W(12)) b1 ();

    assign b0.mode = drv_mode;  assign b1.mode = drv_mode;
    assign b0.in_data = drv_data;  assign b1.in_data = drv_data;
    assign b0.in_valid = drv_valid;  assign b1.in_valid = drv_valid;
    assign b0.in_last = drv_last;  assign b1.in_last = drv_last;
    assign b0.out_ready = drv_ready;  assign b1.out_ready = drv_ready;

    qam_mapper_pipe #(.IQ_W(16), .FIFO_DEPTH(2)) u0 (.clock(clock), .reset(reset), .bus(b0));
    qam_mapper_pipe #(.IQ_W(12), .FIFO_DEPTH(3)) u1 (.clock(clock), .reset(reset), .bus(b1));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one bit and hold it until an edge accepts it (bounded wait).
    task automatic send_bit(input logic b, input logic last, input logic [1:0] m);
        int n;
        n = 0;
        drv_data = b; drv_last = last; drv_mode = m; drv_valid = 1'b1;
        while (!b0.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_wait", 16'(b0.in_ready), 16'h1);
        tick();
        drv_valid = 1'b0;
        drv_last = 1'b0;
    endtask

    task automatic chk_sym(input string tag, input logic [15:0] ei, input logic [15:0] eq,
                           input logic el);
        chk({tag, "_valid"}, 16'(b0.out_valid), 16'h1);
        chk({tag, "_i"}, b0.out_i, ei);
        chk({tag, "_q"}, b0.out_q, eq);
        chk({tag, "_last"}, 16'(b0.out_last), 16'(el));
    endtask

    initial begin
        // Reset values
        repeat (3) tick();
        chk("rst_valid", 16'(b0.out_valid), 16'h0);
        chk("rst_ready", 16'(b0.in_ready), 16'h0);
        chk("rst_i", b0.out_i, 16'h0);
        chk("rst_q", b0.out_q, 16'h0);
        chk("rst_last", 16'(b0.out_last), 16'h0);
        reset = 1'b0;
        tick();
        chk("ready_rise", 16'(b0.in_ready), 16'h1);

        // QPSK 0,1
        send_bit(1'b0, 1'b0, 2'd1);
        chk("qpsk_mid_valid", 16'(b0.out_valid), 16'h0);
        send_bit(1'b1, 1'b0, 2'd1);
        chk_sym("qpsk01", 16'h5A82, 16'hA57E, 1'b0);
        tick();
        chk("qpsk_popped", 16'(b0.out_valid), 16'h0);
        chk("idle_i_zero", b0.out_i, 16'h0);

        // 16-QAM 0,1,1,0 and 1,1,0,0
        send_bit(1'b0, 1'b0, 2'd2);
        send_bit(1'b1, 1'b0, 2'd2);
        send_bit(1'b1, 1'b0, 2'd2);
        send_bit(1'b0, 1'b0, 2'd2);
        chk_sym("qam0110", 16'h796E, 16'hD786, 1'b0);
        send_bit(1'b1, 1'b0, 2'd2);
        send_bit(1'b1, 1'b0, 2'd2);
        send_bit(1'b0, 1'b0, 2'd2);
        send_bit(1'b0, 1'b0, 2'd2);
        chk_sym("qam1100", 16'h8692, 16'h287A, 1'b0);

        // BPSK 1 then 0
        send_bit(1'b1, 1'b0, 2'd0);
        chk_sym("bpsk1", 16'h8001, 16'h0000, 1'b0);
        send_bit(1'b0, 1'b0, 2'd0);
        chk_sym("bpsk0", 16'h7FFF, 16'h0000, 1'b0);

        // Flush a half QPSK symbol, then a fresh one
        send_bit(1'b1, 1'b1, 2'd1);
        chk_sym("flush", 16'hA57E, 16'h5A82, 1'b1);
        send_bit(1'b0, 1'b0, 2'd1);
        chk("fresh_mid_valid", 16'(b0.out_valid), 16'h0);
        send_bit(1'b0, 1'b0, 2'd1);
        chk_sym("fresh", 16'h5A82, 16'h5A82, 1'b0);

        // Mode change mid-symbol is ignored until the boundary
        send_bit(1'b0, 1'b0, 2'd2);
        send_bit(1'b1, 1'b0, 2'd2);
        send_bit(1'b1, 1'b0, 2'd0);
        chk("modechg_mid_valid", 16'(b0.out_valid), 16'h0);
        send_bit(1'b0, 1'b0, 2'd0);
        chk_sym("modechg_qam", 16'h796E, 16'hD786, 1'b0);
        send_bit(1'b1, 1'b0, 2'd0);
        chk_sym("modechg_bpsk", 16'h8001, 16'h0000, 1'b0);
        tick();

        // Backpressure with depth 2
        drv_ready = 1'b0;
        send_bit(1'b0, 1'b0, 2'd1);
        send_bit(1'b0, 1'b0, 2'd1);
        send_bit(1'b1, 1'b0, 2'd1);
        send_bit(1'b1, 1'b0, 2'd1);
        chk("bp_full_ready", 16'(b0.in_ready), 16'h0);
        chk_sym("bp_headA", 16'h5A82, 16'h5A82, 1'b0);
        drv_data = 1'b1; drv_valid = 1'b1; drv_mode = 2'd1;
        repeat (3) tick();
        chk("bp_stall_ready", 16'(b0.in_ready), 16'h0);
        chk_sym("bp_stableA", 16'h5A82, 16'h5A82, 1'b0);
        drv_ready = 1'b1;
        tick();
        chk_sym("bp_headB", 16'hA57E, 16'hA57E, 1'b0);
        chk("bp_ready_back", 16'(b0.in_ready), 16'h1);
        tick();
        chk("bp_drained", 16'(b0.out_valid), 16'h0);
        drv_data = 1'b0;
        tick();
        drv_valid = 1'b0;
        chk_sym("bp_symC", 16'hA57E, 16'h5A82, 1'b0);
        tick();
        chk("bp_no_dup", 16'(b0.out_valid), 16'h0);

        // Reset mid-symbol discards the partial bits
        send_bit(1'b1, 1'b0, 2'd2);
        send_bit(1'b1, 1'b0, 2'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_valid", 16'(b0.out_valid), 16'h0);
        chk("midrst_ready", 16'(b0.in_ready), 16'h0);
        tick();
        send_bit(1'b0, 1'b0, 2'd2);
        send_bit(1'b0, 1'b0, 2'd2);
        chk("midrst_no_partial", 16'(b0.out_valid), 16'h0);
        send_bit(1'b0, 1'b0, 2'd2);
        send_bit(1'b0, 1'b0, 2'd2);
        chk_sym("midrst_qam0000", 16'h287A, 16'h287A, 1'b0);
        chk("w12_qam_i", 16'(b1.out_i), 16'h0287);
        chk("w12_qam_q", 16'(b1.out_q), 16'h0287);

        // IQ_W=12 scaling on QPSK 0,0
        send_bit(1'b0, 1'b0, 2'd1);
        send_bit(1'b0, 1'b0, 2'd1);
        chk("w12_valid", 16'(b1.out_valid), 16'h1);
        chk("w12_qpsk_i", 16'(b1.out_i), 16'h05A8);
        chk("w12_qpsk_q", 16'(b1.out_q), 16'h05A8);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
